// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ALU between two requesters.
// Round-robin arbitration feeds an operand register (S1) that drives the ALU.
// A response register (S2) captures the result, the flags and the illegal-code marker.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic              busy
);

    // Control codes above 3'b100 are illegal; they execute as add and mark the response with err.
    localparam logic [CTRL_W-1:0] CTRL_ADD = {CTRL_W{1'b0}};
    localparam logic [CTRL_W-1:0] CTRL_MAX = CTRL_W'(3'd4);

    function automatic logic ctrl_illegal(input logic [CTRL_W-1:0] code);
        return (code > CTRL_MAX);
    endfunction

    // Operand stage (S1)
    logic              s1_v_r;
    logic              s1_id_r;
    logic [DATA_W-1:0] s1_a_r;
    logic [DATA_W-1:0] s1_b_r;
    logic [CTRL_W-1:0] s1_ctrl_r;
    logic              s1_err_r;
    // Response stage (S2)
    logic              s2_v_r;
    logic              s2_id_r;
    logic [DATA_W-1:0] s2_result_r;
    logic [3:0]        s2_flags_r;
    logic              s2_err_r;
    // Round-robin pointer: the requester granted at the last accepted handshake
    logic              last_gnt_r;

    logic              s2_fire_s;
    logic              s2_load_s;
    logic              s1_free_s;
    logic              grant_s;
    logic              accept_s;
    logic [DATA_W-1:0] sel_a_s;
    logic [DATA_W-1:0] sel_b_s;
    logic [CTRL_W-1:0] sel_ctrl_s;

    assign s2_fire_s = s2_v_r & (s2_id_r ? rsp1_ready : rsp0_ready);
    assign s2_load_s = s1_v_r & (~s2_v_r | s2_fire_s);
    assign s1_free_s = ~s1_v_r | s2_load_s;

    // Round-robin grant: on contention, favour the requester not served last
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_gnt_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign req0_ready = (grant_s == 1'b0) & s1_free_s & reset;
    assign req1_ready = (grant_s == 1'b1) & s1_free_s & reset;
    assign accept_s   = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    // Operand mux for the granted requester
    always_comb begin
        sel_a_s    = req0_a;
        sel_b_s    = req0_b;
        sel_ctrl_s = req0_ctrl;
        if (grant_s) begin
            sel_a_s    = req1_a;
            sel_b_s    = req1_b;
            sel_ctrl_s = req1_ctrl;
        end else begin
            sel_a_s    = req0_a;
            sel_b_s    = req0_b;
            sel_ctrl_s = req0_ctrl;
        end
    end

    // S1: load an accepted op (illegal codes become add); clear when it drains so the ALU sees zeros
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_v_r    <= 1'b0;
            s1_id_r   <= 1'b0;
            s1_a_r    <= {DATA_W{1'b0}};
            s1_b_r    <= {DATA_W{1'b0}};
            s1_ctrl_r <= CTRL_ADD;
            s1_err_r  <= 1'b0;
        end else if (accept_s) begin
            s1_v_r    <= 1'b1;
            s1_id_r   <= grant_s;
            s1_a_r    <= sel_a_s;
            s1_b_r    <= sel_b_s;
            s1_ctrl_r <= ctrl_illegal(sel_ctrl_s) ? CTRL_ADD : sel_ctrl_s;
            s1_err_r  <= ctrl_illegal(sel_ctrl_s);
        end else if (s2_load_s) begin
            s1_v_r    <= 1'b0;
            s1_id_r   <= 1'b0;
            s1_a_r    <= {DATA_W{1'b0}};
            s1_b_r    <= {DATA_W{1'b0}};
            s1_ctrl_r <= CTRL_ADD;
            s1_err_r  <= 1'b0;
        end
    end

    // S2: capture the ALU output when S1 advances; hold until consumed, then clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            s2_v_r      <= 1'b0;
            s2_id_r     <= 1'b0;
            s2_result_r <= {DATA_W{1'b0}};
            s2_flags_r  <= 4'b0000;
            s2_err_r    <= 1'b0;
        end else if (s2_load_s) begin
            s2_v_r      <= 1'b1;
            s2_id_r     <= s1_id_r;
            s2_result_r <= alu_result;
            s2_flags_r  <= alu_flags;
            s2_err_r    <= s1_err_r;
        end else if (s2_fire_s) begin
            s2_v_r      <= 1'b0;
            s2_id_r     <= 1'b0;
            s2_result_r <= {DATA_W{1'b0}};
            s2_flags_r  <= 4'b0000;
            s2_err_r    <= 1'b0;
        end
    end

    // Pointer moves only on an accepted handshake; after reset requester 0 is preferred
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_gnt_r <= 1'b1;
        end else if (accept_s) begin
            last_gnt_r <= grant_s;
        end
    end

    assign alu_a      = s1_a_r;
    assign alu_b      = s1_b_r;
    assign alu_ctrl   = s1_ctrl_r;
    assign rsp0_valid = s2_v_r & ~s2_id_r;
    assign rsp1_valid = s2_v_r & s2_id_r;
    assign rsp_result = s2_result_r;
    assign rsp_flags  = s2_flags_r;
    assign rsp_err    = s2_err_r;
    assign busy       = s1_v_r | s2_v_r;

endmodule
